// File: rtl/cpu_pkg.sv
// Shared CPU constants: mnemonic codes, MIPS opcode/funct fields and the
// loader state encoding. Also used by the CPU decode logic.
package cpu_pkg;

    // Mnemonic codes carried on the loader's in_op field.
    localparam logic [4:0] MN_SLL  = 5'd0;
    localparam logic [4:0] MN_SRL  = 5'd1;
    localparam logic [4:0] MN_SLLV = 5'd2;
    localparam logic [4:0] MN_SRLV = 5'd3;
    localparam logic [4:0] MN_ADD  = 5'd4;
    localparam logic [4:0] MN_SUB  = 5'd5;
    localparam logic [4:0] MN_AND  = 5'd6;
    localparam logic [4:0] MN_OR   = 5'd7;
    localparam logic [4:0] MN_NOR  = 5'd8;
    localparam logic [4:0] MN_SLT  = 5'd9;
    localparam logic [4:0] MN_LW   = 5'd10;
    localparam logic [4:0] MN_SW   = 5'd11;
    localparam logic [4:0] MN_BEQ  = 5'd12;
    localparam logic [4:0] MN_BNE  = 5'd13;
    localparam logic [4:0] MN_ADDI = 5'd14;
    localparam logic [4:0] MN_NOP  = 5'd15;

    // R-type funct field values.
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // I-type primary opcodes.
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_BNE  = 6'b000101;
    localparam logic [5:0] OPC_ADDI = 6'b001000;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // R-type word: special opcode 0 in the top six bits.
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, shamt, funct};
    endfunction

    // I-type word: opcode plus 16-bit immediate.
    function automatic logic [31:0] enc_i(input logic [5:0] opcode, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opcode, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational record-to-instruction encoder. Codes above NOP produce a
// zero word and raise the illegal flag.
module instr_encoder
    import cpu_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    // Select the encoding for the mnemonic; shift-by-constant forms ignore rs.
    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_op)
            MN_SLL:  o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FN_SLL);
            MN_SRL:  o_word = enc_r(5'd0, i_rt, i_rd, i_shamt, FN_SRL);
            MN_SLLV: o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_SLLV);
            MN_SRLV: o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_SRLV);
            MN_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_ADD);
            MN_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_SUB);
            MN_AND:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_AND);
            MN_OR:   o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_OR);
            MN_NOR:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_NOR);
            MN_SLT:  o_word = enc_r(i_rs, i_rt, i_rd, i_shamt, FN_SLT);
            MN_LW:   o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm);
            MN_SW:   o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm);
            MN_BEQ:  o_word = enc_i(OPC_BEQ, i_rs, i_rt, i_imm);
            MN_BNE:  o_word = enc_i(OPC_BNE, i_rs, i_rt, i_imm);
            MN_ADDI: o_word = enc_i(OPC_ADDI, i_rs, i_rt, i_imm);
            MN_NOP:  o_word = 32'h0;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts instruction records, encodes them and
// writes one word per record at consecutive addresses, then releases the CPU.
//
// Handshake: a record transfers on a rising clock edge where in_valid and
// in_ready are both 1; in_ready never depends on in_valid, and in_valid is
// ignored whenever in_ready is 0.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_run,
    output logic [7:0]  load_count,
    output logic        err_op,
    output logic [1:0]  o_dbg_state
);

    localparam logic [7:0] DEPTH_L    = 8'(DEPTH);
    localparam logic [7:0] DEPTH_LAST = 8'(DEPTH - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [7:0]  r_count;
    logic        r_err;

    logic        w_accept;
    logic        w_is_last;
    logic [31:0] w_enc;
    logic        w_illegal;

    assign w_accept  = in_valid && r_ready;
    // The DEPTH-th record closes the program even without in_last.
    assign w_is_last = in_last || (r_count == DEPTH_LAST);

    instr_encoder u_enc (
        .i_op      (in_op),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_shamt   (in_shamt),
        .i_imm     (in_imm),
        .o_word    (w_enc),
        .o_illegal (w_illegal)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: LOAD until the last record, one DRAIN cycle for its write, then RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:  if (w_accept && w_is_last) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_LOAD;
        endcase
    end

    // Ready is registered so it stays low during reset and rises on the first edge after.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_next == ST_LOAD);
        end
    end

    // Write path: register the encoded word one cycle after acceptance and count it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'h0;
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr  <= BASE_ADDR + {22'd0, r_count, 2'b00};
                r_wdata <= w_enc;
                if (r_count != DEPTH_L) begin
                    r_count <= r_count + 8'd1;
                end
                if (w_illegal) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready    = r_ready;
    assign imem_we     = r_we;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign cpu_run     = (r_state == ST_RUN);
    assign load_count  = r_count;
    assign err_op      = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scenario tasks drive records, a negedge monitor
// checks every write against an expected queue of {addr, wdata}.
module tb_imem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_run;
    logic [7:0]  load_count;
    logic        err_op;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    logic [63:0] exp_q[$];

    // Reference model of the handshake.
    bit m_ready, m_started;
    int m_count;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_run(cpu_run), .load_count(load_count), .err_op(err_op),
        .o_dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Independent MIPS encoding model.
    function automatic logic [31:0] exp_enc(input logic [4:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sh, input logic [15:0] imm);
        logic [5:0] fn;
        logic [5:0] opc;
        case (op)
            5'd0:  return {11'd0, rt, rd, sh, 6'h00};
            5'd1:  return {11'd0, rt, rd, sh, 6'h02};
            5'd10: opc = 6'h23;
            5'd11: opc = 6'h2B;
            5'd12: opc = 6'h04;
            5'd13: opc = 6'h05;
            5'd14: opc = 6'h08;
            default: opc = 6'h3F;
        endcase
        if (op >= 5'd10 && op <= 5'd14) return {opc, rs, rt, imm};
        case (op)
            5'd2: fn = 6'h04;
            5'd3: fn = 6'h06;
            5'd4: fn = 6'h20;
            5'd5: fn = 6'h22;
            5'd6: fn = 6'h24;
            5'd7: fn = 6'h25;
            5'd8: fn = 6'h27;
            5'd9: fn = 6'h2A;
            default: return 32'h0;
        endcase
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    // Scoreboard monitor: every write must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%08h wdata=%08h, no write expected", imem_addr, imem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%08h wdata=%08h, expected addr=%08h wdata=%08h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Advance the handshake model across one rising edge.
    task automatic model_edge(input bit acc, input bit last);
        if (acc) begin
            m_count++;
            if (last || m_count == DEPTH) m_ready = 0;
        end
        if (!m_started) begin
            m_started = 1;
            m_ready   = 1;
        end
    endtask

    // Driver: present one record for one cycle (called at a negedge).
    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input bit last);
        bit acc;
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_last = last;
        acc = m_ready;
        if (acc) exp_q.push_back({BASE + 32'(m_count * 4), exp_enc(op, rs, rt, rd, sh, imm)});
        @(posedge clock);
        model_edge(acc, last);
        @(negedge clock);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge(1'b0, 1'b0);
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        m_ready = 0; m_started = 0; m_count = 0;
        idle(1);
    endtask

    task automatic test_reset();
        @(negedge clock);
        #1;
        checks += 8;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", imem_we); end
        if (imem_addr !== BASE) begin errors++; $display("FAIL rst_addr: got %08h want %08h", imem_addr, BASE); end
        if (imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %08h want 0", imem_wdata); end
        if (cpu_run !== 1'b0) begin errors++; $display("FAIL rst_run: got %b want 0", cpu_run); end
        if (load_count !== 8'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", load_count); end
        if (err_op !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_op); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        @(negedge clock);
        reset = 1'b0;
        m_ready = 0; m_started = 0; m_count = 0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
        idle(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        send(5'd14, 5'd0, 5'd16, 5'd0, 5'd0, 16'd9, 1'b0);
        checks += 2;
        if (exp_enc(5'd14, 5'd0, 5'd16, 5'd0, 5'd0, 16'd9) !== 32'h20100009) begin
            errors++; $display("FAIL addi_model: model disagrees with 20100009");
        end
        if (load_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d want 1", load_count); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(5'd4, 5'd8, 5'd16, 5'd8, 5'd0, 16'd0, 1'b0);
        send(5'd10, 5'd10, 5'd13, 5'd0, 5'd0, 16'd4, 1'b0);
        send(5'd0, 5'd7, 5'd2, 5'd20, 5'd12, 16'd0, 1'b1);
        checks += 2;
        if (cpu_run !== 1'b0) begin errors++; $display("FAIL run_early: got %b want 0", cpu_run); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_ready: got %b want 0", in_ready); end
        idle(1);
        checks += 3;
        if (cpu_run !== 1'b1) begin errors++; $display("FAIL run_rise: got %b want 1", cpu_run); end
        if (load_count !== 8'd3) begin errors++; $display("FAIL b2b_count: got %0d want 3", load_count); end
        if (dbg_state !== 2'd2) begin errors++; $display("FAIL b2b_state: got %0d want 2", dbg_state); end
        // Records offered in RUN must be ignored.
        send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
        idle(1);
        checks += 2;
        if (cpu_run !== 1'b1) begin errors++; $display("FAIL run_hold: got %b want 1", cpu_run); end
        if (load_count !== 8'd3) begin errors++; $display("FAIL run_count: got %0d want 3", load_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        send(5'd20, 5'd3, 5'd4, 5'd5, 5'd6, 16'h1234, 1'b0);
        checks++;
        if (err_op !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_op); end
        send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
        send(5'd15, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 1'b1);
        idle(2);
        checks += 2;
        if (err_op !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_op); end
        if (load_count !== 8'd3) begin errors++; $display("FAIL err_count: got %0d want 3", load_count); end
    endtask

    task automatic test_depth();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send(5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535)), 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL depth_ready: got %b want 0", in_ready); end
        send(5'd4, 5'd9, 5'd9, 5'd9, 5'd0, 16'd0, 1'b0);
        checks += 2;
        if (cpu_run !== 1'b1) begin errors++; $display("FAIL depth_run: got %b want 1", cpu_run); end
        if (load_count !== 8'd4) begin errors++; $display("FAIL depth_count: got %0d want 4", load_count); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'd5, 1'b0);
        send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
        // Third record is accepted, then reset lands during its write cycle.
        in_valid = 1'b1; in_op = 5'd6; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_last = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        checks += 5;
        if (imem_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", imem_we); end
        if (imem_addr !== BASE) begin errors++; $display("FAIL mid_addr: got %08h want %08h", imem_addr, BASE); end
        if (imem_wdata !== 32'h0) begin errors++; $display("FAIL mid_wdata: got %08h want 0", imem_wdata); end
        if (load_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", load_count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", in_ready); end
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        m_ready = 0; m_started = 0; m_count = 0;
        idle(1);
        send(5'd9, 5'd4, 5'd5, 5'd6, 5'd0, 16'd0, 1'b1);
        idle(2);
        checks++;
        if (load_count !== 8'd1) begin errors++; $display("FAIL mid_restart_count: got %0d want 1", load_count); end
    endtask

    task automatic test_valid_toggle();
        int w0;
        do_reset();
        w0 = n_writes;
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b0);
        idle(1);
        send(5'd12, 5'd4, 5'd5, 5'd0, 5'd0, 16'hFFFE, 1'b1);
        idle(2);
        checks++;
        if (n_writes - w0 !== 2) begin errors++; $display("FAIL toggle_writes: got %0d want 2", n_writes - w0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_depth();
        test_reset_mid();
        test_valid_toggle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: %0d expected writes never seen, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
